fp32_accumulator: RTL and testbench
===================================

Name: fp32_accumulator

Overview:
- Downstream consumer of the IEEE-754 single-precision multiplier: sums a stream of products into one running FP32 total (dot-product / MAC tail).
- Multi-cycle sign-magnitude adder with an align → add → iterative-normalise FSM.
- Valid/ready on input and output; `in_last` closes a sum and presents it on the output.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 16, width of the accepted-term counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  product word valid.
- in_ready  output  1  block can accept a product this cycle.
- in_data  input  XLEN  FP32 product: sign[31], exp[30:23], frac[22:0].
- in_last  input  1  qualifies in_data as the final term of the current sum.
- out_valid  output  1  final sum available.
- out_ready  input  1  consumer takes the sum.
- out_data  output  XLEN  FP32 sum.
- out_ovf  output  1  sticky: Inf input or overflow occurred in the current sum.
- busy  output  1  FSM not in IDLE.
- count  output  CNT_W  terms accepted in the current sum; wraps modulo 2^CNT_W.

Behaviour:
- Reset values (asynchronous, immediate):
  - in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0, count=0.
  - acc=+0, state=IDLE.
  - Reset mid-operation discards the partial sum and any pending output.
- States: IDLE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch operand and last flag, count+1, go to ALIGN.
- ALIGN (1 cycle):
  - Operand with exp=0 is treated as ±0; denormals flush to zero.
  - Operand with exp=255: acc becomes ±Inf (operand sign), out_ovf=1, skip to exit.
  - If acc is already Inf, it is held unchanged and the FSM skips to exit.
  - Otherwise, right-shift the smaller-exponent 24-bit mantissa (hidden bit included) by the exponent difference.
  - Shifted-out bits are dropped (truncation); a difference ≥25 makes that mantissa 0.
- ADD (1 cycle):
  - Same signs: add magnitudes.
    - On carry, shift right 1 and exp+1.
    - If exp reaches 255, result is ±Inf (0x7F800000 | sign) and out_ovf=1.
  - Different signs: subtract the smaller magnitude (compare exponent, then mantissa) from the larger; sign is that of the larger.
- NORM (1 cycle per step). Each cycle:
  - Mantissa 0: acc=+0 (0x00000000), exit.
  - Mantissa bit 23 set: write acc, exit.
  - Exponent would go below 1: acc=±0, exit.
  - Otherwise: shift left 1, exp−1, stay in NORM.
- Exit: go to DONE if the last flag is latched, else IDLE.
- Timing: with k = leading zeros after ADD, in_ready/out_valid rise 4+k cycles after the accept edge.
- DONE:
  - out_valid=1, out_data=acc, in_ready=0; both are held stable while out_ready=0.
  - On out_ready: acc=+0, out_ovf=0, count=0, go to IDLE.
- Rounding is round-toward-zero throughout; no NaN is ever generated.
- in_last on the first term gives a one-term sum: out_data equals the operand (after flush-to-zero).
- in_ready is 0 in every state except IDLE; in_data is ignored while in_ready=0.

Decomposition:
- Package fp32_pkg holds:
  - SIGN_BIT=31, EXP_W=8, FRAC_W=23, MANT_W=24, BIAS=127, EXP_MAX=255.
  - POS_ZERO=32'h0, POS_INF=32'h7F800000.
  - The state encoding (IDLE, ALIGN, ADD, NORM, DONE).
- One sub-module, fp_mag_addsub (combinational):
  - Inputs: two aligned 24-bit mantissas and an op select.
  - Outputs: 25-bit magnitude result and the result sign select.

Test Plan:
- Reset: hold rst 3 cycles → in_ready=1, out_valid=0, out_data=0x00000000, count=0; release rst mid-NORM → same values immediately.
- 0x3FC00000 (1.5) then 0x40100000 (2.25, in_last) → out_data=0x40700000 (3.75), out_valid 4 cycles after 2nd accept, count=2.
- Cancellation: 0x3F800000 (1.0) then 0xBF700000 (−0.9375, last) → out_data=0x3D800000 (0.0625), out_valid 8 cycles after accept (k=4).
- Exact cancel: 0x40200000 then 0xC0200000 (last) → out_data=0x00000000, out_ovf=0.
- Overflow: 0x7F7FFFFF then 0x7F7FFFFF (last) → out_data=0x7F800000, out_ovf=1; after handshake a new sum 0x3F800000 (last) → 0x3F800000, out_ovf=0.
- Back-pressure: out_ready=0 for 10 cycles in DONE → out_valid/out_data stable, in_ready=0, in_valid pulses ignored and count unchanged.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 field geometry, constants and accumulator FSM encoding
package fp32_pkg;
    localparam int SIGN_BIT = 31;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = 24;
    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
endpackage

// File: rtl/fp_mag_addsub.sv
// fp_mag_addsub: sign-magnitude core, adds or subtracts two aligned 24-bit mantissas
//   a, b  : aligned mantissas (hidden bit included)
//   sub   : 1 = operand signs differ, subtract smaller from larger
//   res   : 25-bit magnitude (bit 24 is the add carry)
//   sel_b : result takes the sign of b
module fp_mag_addsub
    import fp32_pkg::*;
(
    input  logic [MANT_W-1:0] a,
    input  logic [MANT_W-1:0] b,
    input  logic              sub,
    output logic [MANT_W:0]   res,
    output logic              sel_b
);
    always_comb begin
        sel_b = sub && (b > a);
        res = !sub ? {1'b0, a} + {1'b0, b} : sel_b ? {1'b0, b - a} : {1'b0, a - b};
    end
endmodule

// File: rtl/fp32_accumulator.sv
// fp32_accumulator: multi-cycle FP32 running-sum accumulator (round toward zero)
//   in_valid/in_ready/in_data/in_last : product stream, in_last closes the sum
//   out_valid/out_ready/out_data      : final sum, held until taken
//   out_ovf : sticky Inf/overflow flag for the current sum
//   busy    : FSM not idle
//   count   : terms accepted in the current sum
module fp32_accumulator
    import fp32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic             out_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] count
);
    state_t state, state_n, exit_st;
    logic [XLEN-1:0] acc, op;
    logic last_q, ovf, sa, sb, sn, sel_b;
    logic [CNT_W-1:0] cnt;
    logic [MANT_W-1:0] ma, mb, mant, op_m, acc_m;
    logic [MANT_W:0] sum;
    logic [EXP_W-1:0] ex, op_e, acc_e, dif;
    logic op_inf, acc_inf, a_big, norm_end, ovf_add;

    // exp=0 flushes to zero, so the hidden bit is only present for normal numbers
    assign op_e    = op[SIGN_BIT-1:FRAC_W];
    assign acc_e   = acc[SIGN_BIT-1:FRAC_W];
    assign op_m    = op_e == '0 ? '0 : {1'b1, op[FRAC_W-1:0]};
    assign acc_m   = acc_e == '0 ? '0 : {1'b1, acc[FRAC_W-1:0]};
    assign op_inf  = op_e == EXP_W'(EXP_MAX);
    assign acc_inf = acc_e == EXP_W'(EXP_MAX);
    assign a_big   = acc_e >= op_e;
    assign dif     = a_big ? acc_e - op_e : op_e - acc_e;
    assign ovf_add = sum[MANT_W] && ex == EXP_W'(EXP_MAX - 1);
    assign norm_end = mant == '0 || mant[MANT_W-1] || ex <= EXP_W'(1);
    assign exit_st = last_q ? DONE : IDLE;

    fp_mag_addsub u_mag (
        .a    (ma),
        .b    (mb),
        .sub  (sa ^ sb),
        .res  (sum),
        .sel_b(sel_b)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? ALIGN : IDLE;
            ALIGN:   state_n = (op_inf || acc_inf) ? exit_st : ADD;
            ADD:     state_n = ovf_add ? exit_st : NORM;
            NORM:    state_n = norm_end ? exit_st : NORM;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= POS_ZERO;
            op     <= '0;
            last_q <= 1'b0;
            ovf    <= 1'b0;
            cnt    <= '0;
            ma     <= '0;
            mb     <= '0;
            mant   <= '0;
            ex     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            sn     <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (in_valid) begin
                    op     <= in_data;
                    last_q <= in_last;
                    cnt    <= cnt + CNT_W'(1);
                end
                ALIGN: begin
                    if (op_inf) begin
                        acc <= POS_INF | {op[SIGN_BIT], 31'b0};
                        ovf <= 1'b1;
                    end
                    ma <= a_big ? acc_m : acc_m >> dif;
                    mb <= a_big ? op_m >> dif : op_m;
                    ex <= a_big ? acc_e : op_e;
                    sa <= acc[SIGN_BIT];
                    sb <= op[SIGN_BIT];
                end
                ADD: begin
                    sn   <= sel_b ? sb : sa;
                    mant <= sum[MANT_W] ? sum[MANT_W:1] : sum[MANT_W-1:0];
                    ex   <= sum[MANT_W] ? ex + EXP_W'(1) : ex;
                    if (ovf_add) begin
                        acc <= POS_INF | {sa, 31'b0};
                        ovf <= 1'b1;
                    end
                end
                NORM: begin
                    if (mant == '0) acc <= POS_ZERO;
                    else if (mant[MANT_W-1]) acc <= {sn, ex, mant[FRAC_W-1:0]};
                    else if (ex <= EXP_W'(1)) acc <= {sn, 31'b0};
                    else begin
                        mant <= mant << 1;
                        ex   <= ex - EXP_W'(1);
                    end
                end
                DONE: if (out_ready) begin
                    acc <= POS_ZERO;
                    ovf <= 1'b0;
                    cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_data  = acc;
    assign out_ovf   = ovf;
    assign count     = cnt;
endmodule

// File: tb/tb_fp32_accumulator.sv
// tb_fp32_accumulator: table-driven scoreboard bench for fp32_accumulator
module tb_fp32_accumulator;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_last = 0, out_ready = 0;
    logic [31:0] in_data = '0;
    logic in_ready, out_valid, out_ovf, busy;
    logic [31:0] out_data;
    logic [15:0] count;
    int cyc = 0, tests = 0, fails = 0;

    typedef struct {logic [31:0] d; logic o; logic [15:0] n; int lat;} exp_t;
    typedef struct {logic [31:0] a; logic [31:0] b; bit two; logic [31:0] d; logic o; int lat;} vec_t;
    exp_t sb[$];
    vec_t v[12];

    fp32_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // drive one term; c0 is the cycle in which the handshake is presented
    task automatic send(input logic [31:0] d, input logic l, output int c0);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1; in_data = d; in_last = l; c0 = cyc;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
    endtask

    task automatic collect(input int c0);
        exp_t e;
        int n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("out_valid", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: output with no expected entry");
        end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_ovf", 32'(out_ovf), 32'(e.o));
            chk("count", 32'(count), 32'(e.n));
            chk("in_ready_done", 32'(in_ready), 32'd0);
            if (e.lat > 0) chk("latency", 32'(cyc - c0), 32'(e.lat));
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("count_cleared", 32'(count), 32'd0);
        chk("ovf_cleared", 32'(out_ovf), 32'd0);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int c0;
        logic [31:0] held;
        v[0]  = '{32'h3FC00000, 32'h40100000, 1, 32'h40700000, 0, 4};
        v[1]  = '{32'h3F800000, 32'hBF700000, 1, 32'h3D800000, 0, 8};
        v[2]  = '{32'h40200000, 32'hC0200000, 1, 32'h00000000, 0, 4};
        v[3]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1, 32'h7F800000, 1, -1};
        v[4]  = '{32'h3F800000, 32'h0,        0, 32'h3F800000, 0, 4};
        v[5]  = '{32'h00000001, 32'h3F800000, 1, 32'h3F800000, 0, 4};
        v[6]  = '{32'h7F800000, 32'hBF800000, 1, 32'h7F800000, 1, -1};
        v[7]  = '{32'h40400000, 32'hC0800000, 1, 32'hBF800000, 0, 6};
        v[8]  = '{32'h4C000000, 32'h3F800000, 1, 32'h4C000000, 0, 4};
        v[9]  = '{32'h00800000, 32'h80C00000, 1, 32'h80000000, 0, 4};
        v[10] = '{32'h3F800000, 32'h3F800000, 1, 32'h40000000, 0, 4};
        v[11] = '{32'hBFC00000, 32'hBFC00000, 1, 32'hC0400000, 0, 4};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 0;

        foreach (v[i]) begin
            if (v[i].two) send(v[i].a, 1'b0, c0);
            send(v[i].two ? v[i].b : v[i].a, 1'b1, c0);
            sb.push_back('{v[i].d, v[i].o, v[i].two ? 16'd2 : 16'd1, v[i].lat});
            collect(c0);
        end

        // back-pressure: result and handshake state frozen while out_ready=0
        send(32'h3FC00000, 1'b0, c0);
        send(32'h40100000, 1'b1, c0);
        sb.push_back('{32'h40700000, 1'b0, 16'd2, -1});
        repeat (6) @(posedge clk);
        #1;
        chk("bp_valid_start", 32'(out_valid), 32'd1);
        held = out_data;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0]; in_data = 32'h3F800000; in_last = 1;
            @(posedge clk); #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", out_data, held);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_count", 32'(count), 32'd2);
        end
        in_valid = 0; in_last = 0;
        collect(c0);

        // asynchronous reset in the middle of normalisation
        send(32'h3F800000, 1'b0, c0);
        send(32'hBF700000, 1'b1, c0);
        repeat (3) @(posedge clk);
        #1;
        chk("norm_busy", 32'(busy), 32'd1);
        rst = 1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        send(32'h40100000, 1'b1, c0);
        sb.push_back('{32'h40100000, 1'b0, 16'd1, 4});
        collect(c0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
